// File: rtl/uram_readout_scheduler.sv
// =============================================================================
// uram_readout_scheduler
// Tracks filled URAM event buffers, hands them to the readout SM one at a time,
// and grants firmware-loading mode only while no readout is in flight.
// Revision: 1.0
// =============================================================================
`default_nettype none

module uram_readout_scheduler #(
  parameter int NBUF_BITS = 2
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 clk_ce_i,
  input  logic                 ev_done_i,
  output logic [NBUF_BITS-1:0] wr_buf_o,
  output logic                 full_o,
  output logic                 data_available_o,
  output logic [NBUF_BITS-1:0] rd_buf_o,
  input  logic                 complete_i,
  input  logic                 readout_valid_i,
  input  logic                 fw_req_i,
  output logic                 fw_loading_o,
  output logic [NBUF_BITS:0]   occupancy_o,
  output logic                 overflow_o,
  input  logic                 err_clr_i
);

  localparam logic [NBUF_BITS:0] NBUF = {1'b1, {NBUF_BITS{1'b0}}};

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_READOUT = 3'd1,
    ST_DRAIN   = 3'd2,
    ST_FW_WAIT = 3'd3,
    ST_FW      = 3'd4
  } state_t;

  state_t               state_q, state_d;
  logic [NBUF_BITS-1:0] wr_ptr_q, wr_ptr_d;
  logic [NBUF_BITS-1:0] rd_ptr_q, rd_ptr_d;
  logic [NBUF_BITS:0]   cnt_q, cnt_d;
  logic                 data_avail_q, fw_loading_q, overflow_q, overflow_d;
  logic                 wr_ok, rd_ok;

  always_comb begin
    state_d = state_q;
    if (clk_ce_i) begin
      case (state_q)
        ST_IDLE: begin
          if (fw_req_i)            state_d = ST_FW_WAIT;
          else if (cnt_q != '0)    state_d = ST_READOUT;
        end
        ST_READOUT: begin
          if (complete_i)          state_d = ST_DRAIN;
        end
        ST_DRAIN: begin
          if (!readout_valid_i) begin
            if (fw_req_i)          state_d = ST_FW_WAIT;
            else if (cnt_q != '0)  state_d = ST_READOUT;
            else                   state_d = ST_IDLE;
          end
        end
        ST_FW_WAIT: begin
          if (!fw_req_i)           state_d = ST_IDLE;
          else if (!readout_valid_i) state_d = ST_FW;
        end
        ST_FW: begin
          if (!fw_req_i)           state_d = ST_IDLE;
        end
        default:                   state_d = ST_IDLE;
      endcase
    end

    wr_ok = ev_done_i && (cnt_q != NBUF) && (state_q != ST_FW);
    rd_ok = complete_i && (state_q == ST_READOUT);

    wr_ptr_d = wr_ptr_q + NBUF_BITS'(wr_ok);
    rd_ptr_d = rd_ptr_q + NBUF_BITS'(rd_ok);
    cnt_d    = cnt_q;
    if (wr_ok && !rd_ok)      cnt_d = cnt_q + 1'b1;
    else if (!wr_ok && rd_ok) cnt_d = cnt_q - 1'b1;

    // Entering FW discards everything buffered, including a same-cycle event.
    if (state_q == ST_FW_WAIT && state_d == ST_FW) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      cnt_d    = '0;
    end

    if (ev_done_i && !wr_ok) overflow_d = 1'b1;
    else if (err_clr_i)      overflow_d = 1'b0;
    else                     overflow_d = overflow_q;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= ST_IDLE;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      cnt_q        <= '0;
      data_avail_q <= 1'b0;
      fw_loading_q <= 1'b0;
      overflow_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      cnt_q        <= cnt_d;
      data_avail_q <= (state_d == ST_READOUT);
      fw_loading_q <= (state_d == ST_FW);
      overflow_q   <= overflow_d;
    end
  end

  assign wr_buf_o         = wr_ptr_q;
  assign rd_buf_o         = rd_ptr_q;
  assign occupancy_o      = cnt_q;
  assign full_o           = (cnt_q == NBUF) || fw_loading_q;
  assign data_available_o = data_avail_q;
  assign fw_loading_o     = fw_loading_q;
  assign overflow_o       = overflow_q;

endmodule

`default_nettype wire

// File: tb/tb_uram_readout_scheduler.sv
// =============================================================================
// tb_uram_readout_scheduler
// Directed bench: readout handoffs are scored against a queue of expected buffers.
// Revision: 1.0
// =============================================================================
`default_nettype none

module tb_uram_readout_scheduler;

  localparam int NB = 2;

  logic          clk = 1'b0, rst = 1'b1, ce = 1'b0;
  logic          ev = 1'b0, cpl = 1'b0, val = 1'b0, fw = 1'b0, clr = 1'b0;
  logic [NB-1:0] wrb, rdb;
  logic [NB:0]   occ;
  logic          full, da, fwl, ovf;

  int            tests = 0, fails = 0;
  logic [NB-1:0] exp_q[$];
  logic          da_prev = 1'b0;

  uram_readout_scheduler #(.NBUF_BITS(NB)) dut (
    .clk_i(clk), .rst_i(rst), .clk_ce_i(ce), .ev_done_i(ev),
    .wr_buf_o(wrb), .full_o(full), .data_available_o(da), .rd_buf_o(rdb),
    .complete_i(cpl), .readout_valid_i(val), .fw_req_i(fw),
    .fw_loading_o(fwl), .occupancy_o(occ), .overflow_o(ovf), .err_clr_i(clr)
  );

  always #5 clk = ~clk;
  always @(posedge clk) ce <= ~ce;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Scoreboard monitor: every rising data_available_o consumes one expected buffer.
  always @(negedge clk) begin
    logic [NB-1:0] e;
    if (da === 1'b1 && da_prev !== 1'b1) begin
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL sb_unexpected: rd_buf_o got %0d with no handoff expected", rdb);
      end else begin
        e = exp_q.pop_front();
        if (rdb !== e || fwl !== 1'b0) begin
          fails++;
          $display("FAIL sb_handoff: rd_buf_o got %0d fw_loading_o %0d expected %0d and 0", rdb, fwl, e);
        end
      end
    end
    da_prev = da;
  end

  task automatic tick;
    @(negedge clk);
  endtask

  task automatic to_ce;
    while (ce !== 1'b1) @(negedge clk);
  endtask

  task automatic ev_pulse;
    ev = 1'b1;
    tick();
    ev = 1'b0;
  endtask

  task automatic rd_cycle(input int exp_occ);
    to_ce();
    cpl = 1'b1;
    val = 1'b1;
    tick();
    cpl = 1'b0;
    chk("da_fall", da, 0);
    chk("occ_dec", occ, exp_occ);
    repeat (3) tick();
    val = 1'b0;
  endtask

  initial begin
    int n;
    repeat (3) tick();
    chk("reset_outs", {da, fwl, ovf, full, occ, wrb, rdb}, 0);
    rst = 1'b0;
    tick();

    // Fill three buffers, first handoff is buffer 0
    exp_q.push_back(0);
    ev_pulse(); chk("wr_step1", wrb, 1); chk("occ1", occ, 1);
    ev_pulse(); chk("wr_step2", wrb, 2);
    ev_pulse(); chk("wr_step3", wrb, 3); chk("occ3", occ, 3);
    chk("da_first", da, 1); chk("rd_first", rdb, 0);

    exp_q.push_back(1);
    rd_cycle(2); tick(); chk("b2b_da", da, 1); chk("b2b_rd", rdb, 1);
    exp_q.push_back(2);
    rd_cycle(1); tick(); chk("b2b_da2", da, 1);
    rd_cycle(0); repeat (4) tick();
    chk("idle_da", da, 0); chk("idle_occ", occ, 0);

    rst = 1'b1; tick(); rst = 1'b0; tick();

    // Overflow with four buffers
    exp_q.push_back(0);
    ev_pulse(); ev_pulse(); ev_pulse();
    chk("full_3", full, 0); chk("occ_3b", occ, 3);
    ev_pulse();
    chk("full_4", full, 1); chk("occ_4", occ, 4); chk("ovf_none", ovf, 0);
    ev_pulse();
    chk("ovf_set", ovf, 1); chk("wr_wrap", wrb, 0); chk("occ_hold", occ, 4);
    ev = 1'b1; clr = 1'b1; tick(); ev = 1'b0; clr = 1'b0;
    chk("ovf_clr_collide", ovf, 1);
    clr = 1'b1; tick(); clr = 1'b0;
    chk("ovf_clr", ovf, 0);

    exp_q.push_back(1);
    rd_cycle(3); tick(); chk("ro_da3", da, 1);
    exp_q.push_back(2);
    rd_cycle(2); tick(); chk("ro_rd2", rdb, 2);

    // Simultaneous write and read with two filled
    to_ce();
    cpl = 1'b1; ev = 1'b1; val = 1'b1;
    tick();
    cpl = 1'b0; ev = 1'b0;
    chk("sim_occ", occ, 2); chk("sim_rd", rdb, 3); chk("sim_wr", wrb, 1);
    exp_q.push_back(3);
    repeat (3) tick();
    val = 1'b0;
    tick(); chk("sim_next_da", da, 1);

    // Firmware request mid-readout
    fw = 1'b1; val = 1'b1;
    repeat (4) tick();
    chk("fw_blocked", fwl, 0);
    to_ce(); cpl = 1'b1; tick(); cpl = 1'b0;
    chk("fw_occ1", occ, 1);
    repeat (3) tick();
    chk("fw_drain_blocked", fwl, 0);
    val = 1'b0;
    n = 0;
    while (fwl !== 1'b1 && n < 20) begin tick(); n++; end
    chk("fw_grant", fwl, 1); chk("fw_occ0", occ, 0); chk("fw_full", full, 1);
    chk("fw_da", da, 0); chk("fw_ptrs", {wrb, rdb}, 0);
    ev_pulse(); chk("fw_ovf", ovf, 1); chk("fw_occ_drop", occ, 0);
    fw = 1'b0; to_ce(); tick();
    chk("fw_release", fwl, 0); chk("fw_release_full", full, 0);
    clr = 1'b1; tick(); clr = 1'b0;

    // Minimum grant latency from empty IDLE
    to_ce(); fw = 1'b1;
    tick(); chk("fw_lat_early", fwl, 0);
    tick(); tick(); chk("fw_lat", fwl, 1);
    fw = 1'b0; to_ce(); tick(); chk("fw_lat_off", fwl, 0);

    // Asynchronous reset while in READOUT
    exp_q.push_back(0);
    ev_pulse(); ev_pulse();
    n = 0;
    while (da !== 1'b1 && n < 20) begin tick(); n++; end
    chk("pre_rst_da", da, 1);
    #2 rst = 1'b1;
    #1 chk("async_rst", {da, fwl, ovf, full, occ, wrb, rdb}, 0);
    tick(); rst = 1'b0; tick();

    chk("sb_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
